// File: rtl/fp_mul_seq_if.sv
// Handshake bundle for the sequential FP multiplier: operand input channel,
// result output channel and the busy indicator.
interface fp_mul_seq_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  localparam int WORD_W = 1 + EXP_W + FRAC_W;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] op_A;
  logic [WORD_W-1:0] op_B;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] res;
  logic [2:0]        flags;
  logic              busy;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, op_A, op_B, out_ready,
    input  in_ready, out_valid, res, flags, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, op_A, op_B, out_ready,
    output in_ready, out_valid, res, flags, busy
  );
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential single-precision style FP multiplier: exponent sum, radix-2
// shift-add significand multiply, normalize with truncation, special-case
// classification, result held on a valid/ready output.
module fp_mul_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic         clk,
  input  logic         rst,
  fp_mul_seq_if.slave  bus
);

  localparam int WORD_W = 1 + EXP_W + FRAC_W;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int E_W    = EXP_W + 2;
  localparam int CNT_W  = $clog2(SIG_W + 1);

  localparam logic signed [E_W-1:0] BIAS  = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] E_MAX = E_W'((1 << EXP_W) - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(FRAC_W);

  localparam logic [WORD_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXP,
    S_MUL,
    S_NORM,
    S_OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_W-1:0]      a_q, a_d;
  logic [WORD_W-1:0]      b_q, b_d;
  logic                   sign_q, sign_d;
  logic signed [E_W-1:0]  e_q, e_d;
  logic [SIG_W-1:0]       mcand_q, mcand_d;
  logic [SIG_W-1:0]       mplr_q, mplr_d;
  logic [PROD_W-1:0]      prod_q, prod_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0]      res_q, res_d;
  logic [2:0]             flags_q, flags_d;

  // Operand field decode from the latched operands.
  logic               sign_a, sign_b;
  logic [EXP_W-1:0]   exp_a, exp_b;
  logic [FRAC_W-1:0]  frac_a, frac_b;
  logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic signed [E_W-1:0] e_sum;

  assign {sign_a, exp_a, frac_a} = a_q;
  assign {sign_b, exp_b, frac_b} = b_q;

  assign nan_a  = (&exp_a) && (|frac_a);
  assign nan_b  = (&exp_b) && (|frac_b);
  assign inf_a  = (&exp_a) && !(|frac_a);
  assign inf_b  = (&exp_b) && !(|frac_b);
  // Denormals have exp=0 and are flushed, so exp=0 alone means zero.
  assign zero_a = !(|exp_a);
  assign zero_b = !(|exp_b);

  // Two extra bits keep the biased sum from wrapping in either direction.
  assign e_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;

  // One shift-add step: add multiplicand into the upper half, shift right.
  logic [SIG_W:0]  upper_sum;
  assign upper_sum = {1'b0, prod_q[PROD_W-1:SIG_W]}
                   + (mplr_q[0] ? {1'b0, mcand_q} : {(SIG_W+1){1'b0}});

  // Normalization: a set product MSB means the significand product is in [2,4).
  logic signed [E_W-1:0] e_norm;
  logic [FRAC_W-1:0]     frac_norm;
  assign e_norm    = e_q + $signed({{(E_W-1){1'b0}}, prod_q[PROD_W-1]});
  assign frac_norm = prod_q[PROD_W-1] ? prod_q[PROD_W-2 -: FRAC_W]
                                      : prod_q[PROD_W-3 -: FRAC_W];

  // Next-state and datapath update for every state.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    e_d     = e_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.op_A;
          b_d     = bus.op_B;
          state_d = S_EXP;
        end
      end

      S_EXP: begin
        sign_d = sign_a ^ sign_b;
        e_d    = e_sum;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
          res_d   = QNAN;
          flags_d = 3'b100;
          state_d = S_OUT;
        end else if (inf_a || inf_b) begin
          res_d   = {sign_a ^ sign_b, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          flags_d = 3'b000;
          state_d = S_OUT;
        end else if (zero_a || zero_b) begin
          res_d   = {sign_a ^ sign_b, {(EXP_W+FRAC_W){1'b0}}};
          flags_d = 3'b000;
          state_d = S_OUT;
        end else begin
          mcand_d = {1'b1, frac_a};
          mplr_d  = {1'b1, frac_b};
          prod_d  = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        prod_d = {upper_sum, prod_q[SIG_W-1:1]};
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (!e_norm[E_W-1] && (e_norm >= E_MAX)) begin
          res_d   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          flags_d = 3'b010;
        end else if (e_norm[E_W-1] || (e_norm == '0)) begin
          res_d   = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
          flags_d = 3'b001;
        end else begin
          res_d   = {sign_q, e_norm[EXP_W-1:0], frac_norm};
          flags_d = 3'b000;
        end
        state_d = S_OUT;
      end

      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      e_q     <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      e_q     <= e_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.res       = res_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: normal products, normalization carry,
// overflow/underflow edges, special cases, backpressure and mid-run reset.
module tb_fp_mul_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_pass   = 0;
  int n_checks = 0;

  fp_mul_seq_if #(.EXP_W(8), .FRAC_W(23)) bus ();

  fp_mul_seq #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one operand pair, wait for the result, optionally hold off the
  // consumer for `hold` cycles (pulsing in_valid with decoy operands),
  // then complete the output handshake.
  task automatic run_op(input string tag,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [2:0] exp_flags,
                        input int exp_lat, input int hold);
    int lat;
    int busy_err;
    int stable_err;
    logic [31:0] res0;
    logic [2:0]  flags0;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.op_A     = a;
    bus.op_B     = b;
    bus.in_valid = 1'b1;
    tick();                       // accept edge
    bus.in_valid = 1'b0;
    bus.op_A     = 32'hDEADBEEF;  // later changes must have no effect
    bus.op_B     = 32'h12345678;
    lat      = 0;
    busy_err = 0;
    while (!bus.out_valid && lat < 100) begin
      if (!bus.busy || bus.in_ready) busy_err++;
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_err), 32'd0);
    check({tag, "_res"}, bus.res, exp_res);
    check({tag, "_flags"}, 32'(bus.flags), 32'(exp_flags));
    if (hold > 0) begin
      res0       = bus.res;
      flags0     = bus.flags;
      stable_err = 0;
      for (int i = 0; i < hold; i++) begin
        if (i == 3) begin
          bus.op_A     = 32'h40400000;
          bus.op_B     = 32'h40400000;
          bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
        tick();
        if (!bus.out_valid || bus.in_ready || !bus.busy ||
            bus.res !== res0 || bus.flags !== flags0) stable_err++;
      end
      bus.in_valid = 1'b0;
      check({tag, "_hold_stable"}, 32'(stable_err), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();                       // output handshake edge
    bus.out_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_A      = '0;
    bus.op_B      = '0;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_res",       bus.res,            32'h00000000);
    check("rst_flags",     32'(bus.flags),     32'd0);

    // Normal path: 26-cycle latency.
    run_op("mul_1p5x2",    32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26, 0);
    run_op("mul_1p5x1p5",  32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26, 0);
    run_op("mul_neg1x3",   32'hBF800000, 32'h40400000, 32'hC0400000, 3'b000, 26, 0);
    run_op("mul_trunc",    32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000, 26, 0);

    // Exponent range edges.
    run_op("ovf_big",      32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, 26, 0);
    run_op("max_finite",   32'h7F000000, 32'h3F800000, 32'h7F000000, 3'b000, 26, 0);
    run_op("ovf_e255",     32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010, 26, 0);
    run_op("unf_small",    32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 26, 0);
    run_op("unf_e0",       32'h00800000, 32'h3F000000, 32'h00000000, 3'b001, 26, 0);
    run_op("min_normal",   32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, 26, 0);

    // Special path: 1-cycle latency.
    run_op("inf_x_zero",   32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100, 1, 0);
    run_op("ninf_x_2",     32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1, 0);
    run_op("nan_x_1",      32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b100, 1, 0);
    run_op("nzero_x_2",    32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 1, 0);
    run_op("denorm_x_2",   32'h00000001, 32'h40000000, 32'h00000000, 3'b000, 1, 0);

    // Backpressure with a decoy in_valid pulse, then an unrelated follow-up.
    run_op("bp_1p5x2",     32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26, 10);
    run_op("bp_next",      32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26, 0);

    // Reset during MUL cycle 10 discards the in-flight product.
    bus.op_A     = 32'h3FC00000;
    bus.op_B     = 32'h40000000;
    bus.in_valid = 1'b1;
    tick();                       // accept
    bus.in_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick();  // EXP, then MUL cycles 0..9
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_busy",      32'(bus.busy),      32'd0);
    check("mrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mrst_res",       bus.res,            32'h00000000);
    tick();
    tick();
    check("mrst_idle_valid", 32'(bus.out_valid), 32'd0);
    run_op("post_rst",     32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
